// File: rtl/mvu_pump_bridge.sv
// Double-pumped bridge between a slow-clock MVU/VVU datapath and a 2x-clocked
// compute core: splits each slow word into Lo/Hi halves and re-widens results.
module mvu_pump_bridge #(
  parameter int PE               = 1,
  parameter int SIMD             = 2,
  parameter int ACT_PE           = 1,
  parameter int WEIGHT_WIDTH     = 8,
  parameter int ACTIVATION_WIDTH = 8,
  parameter int ACCU_WIDTH       = 32,
  parameter int IN_REGS          = 1
) (
  input  logic                                         clk2x,
  input  logic                                         rst,
  input  logic [PE*SIMD*WEIGHT_WIDTH-1:0]              in_w,
  input  logic [ACT_PE*SIMD*ACTIVATION_WIDTH-1:0]      in_a,
  input  logic                                         in_zero,
  input  logic                                         in_last,
  output logic [PE*((SIMD+1)/2)*WEIGHT_WIDTH-1:0]      core_w,
  output logic [ACT_PE*((SIMD+1)/2)*ACTIVATION_WIDTH-1:0] core_a,
  output logic                                         core_zero,
  output logic                                         core_last,
  input  logic                                         core_vld,
  input  logic [PE*ACCU_WIDTH-1:0]                     core_p,
  output logic                                         out_vld,
  output logic [PE*ACCU_WIDTH-1:0]                     out_p,
  output logic                                         err_overlap,
  output logic                                         err_last
);

  localparam int CORE_SIMD = (SIMD + 1) / 2;
  localparam int HW        = CORE_SIMD * WEIGHT_WIDTH;      // one half, one lane
  localparam int HA        = CORE_SIMD * ACTIVATION_WIDTH;
  localparam int CW        = PE * HW;
  localparam int CA        = ACT_PE * HA;

  if (ACT_PE != 1 && ACT_PE != PE) begin : g_bad_act_pe
    $fatal(1, "mvu_pump_bridge: ACT_PE must be 1 or PE");
  end
  if (IN_REGS < 1 || IN_REGS > 3) begin : g_bad_in_regs
    $fatal(1, "mvu_pump_bridge: IN_REGS must be in 1..3");
  end

  // Per-lane zero extension to 2*CORE_SIMD elements; pad slots are hard zeros.
  logic [CW-1:0] lo_w, hi_w;
  logic [CA-1:0] lo_a, hi_a;

  for (genvar p = 0; p < PE; p++) begin : g_w_lane
    logic [2*HW-1:0] pad;
    assign pad = (2*HW)'(in_w[p*SIMD*WEIGHT_WIDTH +: SIMD*WEIGHT_WIDTH]);
    assign lo_w[p*HW +: HW] = pad[0  +: HW];
    assign hi_w[p*HW +: HW] = pad[HW +: HW];
  end

  for (genvar p = 0; p < ACT_PE; p++) begin : g_a_lane
    logic [2*HA-1:0] pad;
    assign pad = (2*HA)'(in_a[p*SIMD*ACTIVATION_WIDTH +: SIMD*ACTIVATION_WIDTH]);
    assign lo_a[p*HA +: HA] = pad[0  +: HA];
    assign hi_a[p*HA +: HA] = pad[HA +: HA];
  end

  logic                            active_q, active_d;
  logic [IN_REGS-1:0][CW-1:0]      w_q, w_d;
  logic [IN_REGS-1:0][CA-1:0]      a_q, a_d;
  logic [IN_REGS-1:0]              zero_q, zero_d;
  logic [IN_REGS-1:0]              last_q, last_d;
  logic                            out_vld_q, out_vld_d;
  logic [PE*ACCU_WIDTH-1:0]        out_p_q, out_p_d;
  logic                            err_overlap_q, err_overlap_d;
  logic                            err_last_q, err_last_d;
  logic                            last_pend_q, last_pend_d;
  logic                            step;

  always_comb begin
    active_d  = ~active_q;
    w_d[0]    = active_q ? hi_w : lo_w;
    a_d[0]    = active_q ? hi_a : lo_a;
    zero_d[0] = in_zero;
    last_d[0] = in_last & ~in_zero & active_q;
    for (int k = 1; k < IN_REGS; k++) begin
      w_d[k]    = w_q[k-1];
      a_d[k]    = a_q[k-1];
      zero_d[k] = zero_q[k-1];
      last_d[k] = last_q[k-1];
    end

    // Result stays up through the next slow edge; a new one landing while
    // a result still awaits that edge overwrites it.
    out_vld_d     = core_vld | (out_vld_q & ~active_q);
    out_p_d       = core_vld ? core_p : out_p_q;
    err_overlap_d = err_overlap_q | (core_vld & out_vld_q & ~active_q);

    // Slow-cycle last tracking; bubbles neither extend nor break a run.
    step        = active_q & ~in_zero;
    last_pend_d = step ? in_last : last_pend_q;
    err_last_d  = err_last_q | (step & in_last & last_pend_q);
  end

  always_ff @(posedge clk2x) begin
    if (rst) begin
      active_q      <= 1'b0;
      w_q           <= '0;
      a_q           <= '0;
      zero_q        <= '1;
      last_q        <= '0;
      out_vld_q     <= 1'b0;
      out_p_q       <= '0;
      err_overlap_q <= 1'b0;
      err_last_q    <= 1'b0;
      last_pend_q   <= 1'b0;
    end else begin
      active_q      <= active_d;
      w_q           <= w_d;
      a_q           <= a_d;
      zero_q        <= zero_d;
      last_q        <= last_d;
      out_vld_q     <= out_vld_d;
      out_p_q       <= out_p_d;
      err_overlap_q <= err_overlap_d;
      err_last_q    <= err_last_d;
      last_pend_q   <= last_pend_d;
    end
  end

  assign core_w      = w_q[IN_REGS-1];
  assign core_a      = a_q[IN_REGS-1];
  assign core_zero   = zero_q[IN_REGS-1];
  assign core_last   = last_q[IN_REGS-1];
  assign out_vld     = out_vld_q;
  assign out_p       = out_p_q;
  assign err_overlap = err_overlap_q;
  assign err_last    = err_last_q;

endmodule

// File: tb/tb_mvu_pump_bridge.sv
// Directed bench: SIMD=3 bridge with IN_REGS=1 and IN_REGS=3 copies on shared inputs.
module tb_mvu_pump_bridge;

  logic        clk2x = 1'b0;
  logic        rst;
  logic [23:0] in_w, in_a;
  logic        in_zero, in_last;
  logic        core_vld;
  logic [31:0] core_p;

  logic [15:0] core_w, core_a, core_w3, core_a3;
  logic        core_zero, core_last, core_zero3, core_last3;
  logic        out_vld, out_vld3, err_ov, err_ov3, err_last, err_last3;
  logic [31:0] out_p, out_p3;

  int n_checks = 0;
  int n_errors = 0;
  bit nxt_act  = 1'b0;  // phase the DUT will sample at the next edge

  always #5 clk2x = ~clk2x;

  mvu_pump_bridge #(.PE(1), .SIMD(3), .ACT_PE(1), .IN_REGS(1)) u_dut (
    .clk2x(clk2x), .rst(rst), .in_w(in_w), .in_a(in_a),
    .in_zero(in_zero), .in_last(in_last),
    .core_w(core_w), .core_a(core_a), .core_zero(core_zero), .core_last(core_last),
    .core_vld(core_vld), .core_p(core_p), .out_vld(out_vld), .out_p(out_p),
    .err_overlap(err_ov), .err_last(err_last));

  mvu_pump_bridge #(.PE(1), .SIMD(3), .ACT_PE(1), .IN_REGS(3)) u_dut3 (
    .clk2x(clk2x), .rst(rst), .in_w(in_w), .in_a(in_a),
    .in_zero(in_zero), .in_last(in_last),
    .core_w(core_w3), .core_a(core_a3), .core_zero(core_zero3), .core_last(core_last3),
    .core_vld(core_vld), .core_p(core_p), .out_vld(out_vld3), .out_p(out_p3),
    .err_overlap(err_ov3), .err_last(err_last3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk2x);
    #1;
    nxt_act = rst ? 1'b0 : ~nxt_act;
  endtask

  task automatic align(input bit ph);
    for (int i = 0; i < 2 && nxt_act != ph; i++) tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_w = '0; in_a = '0; in_zero = 1'b1; in_last = 1'b0;
    core_vld = 1'b0; core_p = '0;
    repeat (3) tick;
    core_vld = 1'b1; core_p = 32'h5;   // must be ignored under reset
    tick;
    chk("rst_w", core_w, 0);       chk("rst_a", core_a, 0);
    chk("rst_zero", core_zero, 1); chk("rst_last", core_last, 0);
    chk("rst_vld", out_vld, 0);    chk("rst_p", out_p, 0);
    chk("rst_eov", err_ov, 0);     chk("rst_elast", err_last, 0);
    chk("rst_zero3", core_zero3, 1);
    core_vld = 1'b0;

    // element order {3,2,1}: Lo={1,2}, Hi={3,pad}
    rst = 1'b0; in_w = 24'h030201; in_a = 24'h060504; in_zero = 1'b0; in_last = 1'b0;
    tick;
    chk("lo_w", core_w, 16'h0201); chk("lo_a", core_a, 16'h0504);
    chk("lo_zero", core_zero, 0);  chk("zero3_lat", core_zero3, 1);
    tick;
    chk("hi_w", core_w, 16'h0003); chk("hi_a", core_a, 16'h0006);
    in_last = 1'b1;
    tick;
    chk("last_lo", core_last, 0);  chk("lo_w3", core_w3, 16'h0201);
    tick;
    chk("last_hi", core_last, 1);  chk("hi_w3", core_w3, 16'h0003);
    in_last = 1'b0;
    tick;
    chk("last_drop", core_last, 0);
    tick;
    chk("last3", core_last3, 1);
    in_last = 1'b1;                  // non-last slow cycle sat in between
    tick; tick;
    chk("elast_broken", err_last, 0); chk("last_again", core_last, 1);
    in_zero = 1'b1;                  // bubble with last
    tick;
    chk("bubble_zero", core_zero, 1);
    tick;
    chk("bubble_nolast", core_last, 0); chk("elast_bubble0", err_last, 0);
    in_zero = 1'b0;
    tick; tick;
    chk("elast_bubble", err_last, 1);
    in_last = 1'b0;
    tick; tick;

    // pulse sampled on Active=0: result visible for one fast cycle
    align(1'b0);
    core_vld = 1'b1; core_p = 32'h1234;
    tick;
    chk("p0_vld", out_vld, 1); chk("p0_p", out_p, 32'h1234);
    core_vld = 1'b0;
    tick;
    chk("p0_vld_off", out_vld, 0); chk("p0_hold", out_p, 32'h1234);

    // pulse sampled on Active=1: held across the slow edge, two fast cycles
    align(1'b1);
    core_vld = 1'b1; core_p = 32'hABCD;
    tick;
    chk("p1_vld", out_vld, 1);
    core_vld = 1'b0;
    tick;
    chk("p1_vld_hold", out_vld, 1);
    tick;
    chk("p1_vld_off", out_vld, 0); chk("p1_p", out_p, 32'hABCD);

    // back-to-back where the first result already made its slow edge
    align(1'b0);
    core_vld = 1'b1; core_p = 32'h55;
    tick;
    core_p = 32'h66;
    tick;
    chk("adj_eov", err_ov, 0); chk("adj_p", out_p, 32'h66);
    core_vld = 1'b0;
    tick;
    chk("adj_vld_hold", out_vld, 1);

    // second result arrives while first still awaits its slow edge
    align(1'b1);
    core_vld = 1'b1; core_p = 32'h1111;
    tick;
    core_p = 32'h2222;
    tick;
    chk("ov_set", err_ov, 1); chk("ov_p", out_p, 32'h2222); chk("ov_set3", err_ov3, 1);
    core_vld = 1'b0;
    tick; tick;
    chk("ov_sticky", err_ov, 1); chk("ov_p_hold", out_p, 32'h2222);

    // reset mid-stream
    rst = 1'b1;
    tick;
    chk("mrst_w3", core_w3, 0);      chk("mrst_a3", core_a3, 0);
    chk("mrst_zero3", core_zero3, 1); chk("mrst_last3", core_last3, 0);
    chk("mrst_vld3", out_vld3, 0);   chk("mrst_p3", out_p3, 0);
    chk("mrst_eov", err_ov, 0);      chk("mrst_elast", err_last, 0);
    rst = 1'b0; in_w = 24'h0C0B0A; in_a = 24'h0F0E0D; in_last = 1'b1;
    tick;
    chk("post_lo", core_w, 16'h0B0A); chk("post_lo_a", core_a, 16'h0E0D);
    tick;
    chk("post_hi", core_w, 16'h000C); chk("post_last", core_last, 1);
    tick;
    chk("post_lo3", core_w3, 16'h0B0A); chk("post_zero3", core_zero3, 0);
    chk("elast_one", err_last, 0);
    tick;
    chk("elast_consec", err_last, 1); chk("post_hi3", core_w3, 16'h000C);
    in_last = 1'b0;
    tick; tick;
    chk("elast_sticky", err_last, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
